bus_tx_fifo: RTL and testbench
==============================

# bus_tx_fifo

Bus-attached sub-module that accepts 16-bit words written by the DSP over the external data bus and queues them for fabric-side logic. It sits beside the other bus sub-modules under the bidirectional bus block, consumes `write_qualified`/`read_qualified`/`ab`/`db_in`, and returns status through its own `db_out` register and `data_avail` flag into the read-data mux. On the fabric side, a consumer pops words with a simple read-enable handshake.

## Interface
- `offset_to_add_to_ab`, 0: added to every register address constant.
- `DEPTH_LOG2`, 4: the FIFO depth is 2^DEPTH_LOG2 words (16 by default).
- `xclk` in 1: the single clock, the DSP external bus clock.
- `reset` in 1: **asynchronous, active-low** reset.
- `write_qualified` in 1: the bus write is qualified. It stays high for several cycles per DSP write.
- `read_qualified` in 1: the bus read is qualified. It stays high for the whole DSP read.
- `ab` in 8: the low byte of the address bus.
- `db_in` in 16: write data from the bus.
- `db_out_TX` out 16: read data to the parent mux.
- `data_from_TX_avail` out 1: this module owns the current read.
- `fifo_rd_en` in 1: fabric pop request.
- `fifo_dout` out 16: popped word.
- `fifo_dout_valid` out 1: `fifo_dout` holds a newly popped word this cycle.
- `fifo_empty` out 1: the FIFO holds no words.

## Operation
- Register map, with each address plus `offset_to_add_to_ab`:
  - `TX_DATA` = 0x60, write only: push `db_in`.
  - `TX_STATUS` = 0x61, read only.
  - `TX_CTRL` = 0x62, write only:
    - bit0 = flush.
    - bit1 = clear sticky flags.
- `TX_STATUS` bit layout:
  - [4:0] = count (width DEPTH_LOG2+1).
  - [8] = empty.
  - [9] = full.
  - [10] = overflow (sticky).
  - [11] = underflow (sticky).
  - all other bits read 0.
- A write acts once per DSP strobe, on the rising edge of (`write_qualified` & address match). The module registers the previous `write_qualified` to detect this edge; held-high cycles do nothing.
- Push to `TX_DATA`:
  - If not full: store the word at the write pointer, advance the pointer, and increment count.
  - If full: drop the word and set overflow.
- `TX_CTRL` write:
  - flush resets both pointers and the count to 0.
  - clear-sticky clears overflow and underflow.
  - Both bits may be set in a single write.
- Read: while `read_qualified` & (`ab` == `TX_STATUS`), the module registers `data_from_TX_avail`=1 and `db_out_TX`=status on the next edge. When the read ends or the address mismatches, both drop on the next edge and `db_out_TX` returns to 0.
- Reads from any other address leave `data_from_TX_avail` low.
- Fabric pop: when `fifo_rd_en` is high and the FIFO is not empty, the module registers `fifo_dout` from the read pointer, pulses `fifo_dout_valid` for 1 cycle, advances the read pointer and decrements count.
- Pop when empty: `fifo_dout_valid` stays 0, `fifo_dout` holds its value, and underflow is set.
- Simultaneous push and pop: both take effect and count is unchanged. If the FIFO is full, the pop frees no space that cycle, so the push is dropped and overflow is set. If the FIFO is empty, the pop fails with underflow and the push still succeeds.
- Flush in the same cycle as a pop or push: flush wins. The pop and push are ignored and no flags change.
- Pointers are DEPTH_LOG2 bits and wrap modulo the depth. Full and empty are derived from count.

## Timing
- Reset values (asynchronous):
  - pointers, count, flags, `db_out_TX`, `fifo_dout` = 0.
  - `data_from_TX_avail` = 0, `fifo_dout_valid` = 0.
  - `fifo_empty` = 1.
- Push latency: the count update is visible 1 cycle after the rising edge of `write_qualified`.
- Status read latency: 1 cycle. Its timing matches the parent's registered output-enable, so data is valid on the first driven cycle. Status is re-sampled every cycle of the read.
- Pop latency: `fifo_dout` and `fifo_dout_valid` follow 1 cycle after `fifo_rd_en`. `fifo_rd_en` may be held high for back-to-back pops, one per cycle.
- `fifo_empty` is registered and updates on the same edge as the count.
- Reset mid-read or mid-write: all state clears immediately. A write strobe still high after reset releases does not push, because the edge detector resets to 1 (high).

## Structure
- Register address constants `TX_DATA`, `TX_STATUS` and `TX_CTRL` are added to the shared address-bus definitions include.
- The status bit positions are defined as localparams in that include.
- One sub-module, `tx_fifo_ram`: a 2^DEPTH_LOG2 x 16 array with a synchronous write port and a synchronous read port. All control logic stays in `bus_tx_fifo`.

## Test plan
- **Push and pop in order:** push 0x1111, 0x2222 and 0x3333, each with `write_qualified` held high for 4 cycles. Status reads count=3. Three pops return 0x1111, 0x2222, 0x3333 in order, then `fifo_empty`=1.
- **Overflow:** push 17 words 0x0000..0x0010. Status = 0x0610 (count 16, full, overflow). Popping all 16 words returns 0x0000..0x000F, and 0x0010 is absent.
- **Underflow and clear:** pop while empty gives `fifo_dout_valid`=0 and status bit11=1. Writing `TX_CTRL`=0x0002 clears bit11, and status then reads 0x0100.
- **Wrap-around:** run 40 push/pop pairs with data = index. Every popped word matches, and the count never exceeds 1.
- **Simultaneous events:**
  - Full FIFO, push plus pop in the same cycle: push dropped, overflow set, count 15.
  - Same-cycle flush plus pop: count 0, `fifo_dout_valid`=0.
- **Read mux and reset:**
  - A read at `TX_STATUS` asserts `data_from_TX_avail` 1 cycle after `read_qualified`. A read at `TX_STATUS`+1 never asserts it.
  - Asserting reset during a read zeroes `db_out_TX` immediately.

Source files
------------

// File: rtl/bus_tx_fifo_pkg.sv
// Shared bus register map for the TX FIFO: address constants, status bit positions and
// control bit positions, plus a helper that applies the per-instance address offset.
package bus_tx_fifo_pkg;

  typedef logic [15:0] word_t;

  localparam logic [7:0] TX_DATA   = 8'h60;
  localparam logic [7:0] TX_STATUS = 8'h61;
  localparam logic [7:0] TX_CTRL   = 8'h62;

  localparam int ST_EMPTY_BIT = 8;
  localparam int ST_FULL_BIT  = 9;
  localparam int ST_OVF_BIT   = 10;
  localparam int ST_UNF_BIT   = 11;

  localparam int CTRL_FLUSH_BIT = 0;
  localparam int CTRL_CLR_BIT   = 1;

  function automatic logic [7:0] reg_addr(input logic [7:0] base, input int offset);
    return base + 8'(offset);
  endfunction

endpackage

// File: rtl/tx_fifo_ram.sv
// Storage for the TX FIFO: synchronous write port and a registered read port whose
// output holds its last value whenever no read is requested.
module tx_fifo_ram #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bus_tx_fifo.sv
// DSP-bus to fabric TX FIFO: bus writes push words (one per write strobe), the fabric pops
// with fifo_rd_en, and a registered status word is returned on reads of TX_STATUS.
module bus_tx_fifo
  import bus_tx_fifo_pkg::*;
#(
  parameter int offset_to_add_to_ab = 0,
  parameter int DEPTH_LOG2          = 4
) (
  input  logic        xclk,
  input  logic        reset,
  input  logic        write_qualified,
  input  logic        read_qualified,
  input  logic [7:0]  ab,
  input  logic [15:0] db_in,
  output logic [15:0] db_out_TX,
  output logic        data_from_TX_avail,
  input  logic        fifo_rd_en,
  output logic [15:0] fifo_dout,
  output logic        fifo_dout_valid,
  output logic        fifo_empty
);

  localparam int             CW        = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]  DEPTH     = CW'(2**DEPTH_LOG2);
  localparam logic [7:0]     ADDR_DATA = reg_addr(TX_DATA, offset_to_add_to_ab);
  localparam logic [7:0]     ADDR_STAT = reg_addr(TX_STATUS, offset_to_add_to_ab);
  localparam logic [7:0]     ADDR_CTRL = reg_addr(TX_CTRL, offset_to_add_to_ab);

  logic                  wq_prev;
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [CW-1:0]         count, count_next;
  logic                  ovf, unf;
  logic                  wr_edge, push_req, ctrl_wr, flush, clr_sticky;
  logic                  full, empty_now, do_push, do_pop, rd_hit;
  word_t                 status;

  // A DSP write holds write_qualified for several cycles; only its first cycle acts.
  assign wr_edge    = write_qualified & ~wq_prev;
  assign push_req   = wr_edge & (ab == ADDR_DATA);
  assign ctrl_wr    = wr_edge & (ab == ADDR_CTRL);
  assign flush      = ctrl_wr & db_in[CTRL_FLUSH_BIT];
  assign clr_sticky = ctrl_wr & db_in[CTRL_CLR_BIT];

  assign full      = (count == DEPTH);
  assign empty_now = (count == '0);
  // Full is judged before the pop, so a same-cycle pop never makes room for the push.
  assign do_push   = push_req & ~full & ~flush;
  assign do_pop    = fifo_rd_en & ~empty_now & ~flush;
  assign rd_hit    = read_qualified & (ab == ADDR_STAT);

  always_comb begin
    count_next = count;
    if (flush) count_next = '0;
    else       count_next = count + CW'(do_push) - CW'(do_pop);
  end

  always_comb begin
    status               = '0;
    status[CW-1:0]       = count;
    status[ST_EMPTY_BIT] = empty_now;
    status[ST_FULL_BIT]  = full;
    status[ST_OVF_BIT]   = ovf;
    status[ST_UNF_BIT]   = unf;
  end

  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      wq_prev            <= 1'b1;
      wptr               <= '0;
      rptr               <= '0;
      count              <= '0;
      ovf                <= 1'b0;
      unf                <= 1'b0;
      fifo_empty         <= 1'b1;
      fifo_dout_valid    <= 1'b0;
      data_from_TX_avail <= 1'b0;
      db_out_TX          <= '0;
    end else begin
      wq_prev    <= write_qualified;
      count      <= count_next;
      fifo_empty <= (count_next == '0);
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (do_push) wptr <= wptr + DEPTH_LOG2'(1);
        if (do_pop)  rptr <= rptr + DEPTH_LOG2'(1);
      end
      ovf <= (ovf & ~clr_sticky) | (push_req & full & ~flush);
      unf <= (unf & ~clr_sticky) | (fifo_rd_en & empty_now & ~flush);
      fifo_dout_valid    <= do_pop;
      data_from_TX_avail <= rd_hit;
      db_out_TX          <= rd_hit ? status : '0;
    end
  end

  tx_fifo_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (16)
  ) u_ram (
    .clk   (xclk),
    .rst_n (reset),
    .we    (do_push),
    .waddr (wptr),
    .wdata (db_in),
    .re    (do_pop),
    .raddr (rptr),
    .rdata (fifo_dout)
  );

endmodule

// File: tb/tb_bus_tx_fifo.sv
// Bench for bus_tx_fifo: vector table for the basic flow plus hand-written corner sequences,
// with a queue of expected words that is filled on push and drained on pop.
module tb_bus_tx_fifo;

  localparam int OP_WR = 0, OP_RD = 1, OP_POP = 2, OP_EMPTY = 3, OP_RDX = 4;

  typedef struct {
    int          op;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  logic        xclk = 1'b0;
  logic        reset = 1'b0;
  logic        write_qualified = 1'b0;
  logic        read_qualified = 1'b0;
  logic [7:0]  ab = 8'h00;
  logic [15:0] db_in = 16'h0000;
  logic [15:0] db_out_TX;
  logic        data_from_TX_avail;
  logic        fifo_rd_en = 1'b0;
  logic [15:0] fifo_dout;
  logic        fifo_dout_valid;
  logic        fifo_empty;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] sb[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;
  vec_t        vecs[14];

  bus_tx_fifo #(.offset_to_add_to_ab(0), .DEPTH_LOG2(4)) dut (
    .xclk               (xclk),
    .reset              (reset),
    .write_qualified    (write_qualified),
    .read_qualified     (read_qualified),
    .ab                 (ab),
    .db_in              (db_in),
    .db_out_TX          (db_out_TX),
    .data_from_TX_avail (data_from_TX_avail),
    .fifo_rd_en         (fifo_rd_en),
    .fifo_dout          (fifo_dout),
    .fifo_dout_valid    (fifo_dout_valid),
    .fifo_empty         (fifo_empty)
  );

  always #5 xclk = ~xclk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge xclk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_status(input int cnt, input bit o, input bit u);
    logic [15:0] s;
    s = 16'(cnt);
    if (cnt == 0)  s = s | 16'h0100;
    if (cnt == 16) s = s | 16'h0200;
    if (o)         s = s | 16'h0400;
    if (u)         s = s | 16'h0800;
    return s;
  endfunction

  task automatic bus_write(input logic [7:0] addr, input logic [15:0] data);
    ab = addr;
    db_in = data;
    write_qualified = 1'b1;
    repeat (4) tick();
    write_qualified = 1'b0;
    tick();
  endtask

  task automatic push_sb(input logic [15:0] data);
    bus_write(8'h60, data);
    if (sb.size() < 16) sb.push_back(data);
    else m_ovf = 1'b1;
  endtask

  task automatic clear_flags();
    bus_write(8'h62, 16'h0002);
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic read_status(input string name, input logic [15:0] exp);
    ab = 8'h61;
    read_qualified = 1'b1;
    tick();
    check({name, " avail"}, 16'(data_from_TX_avail), 16'h0001);
    check(name, db_out_TX, exp);
    read_qualified = 1'b0;
    tick();
  endtask

  task automatic pop_sb(input string name);
    logic [15:0] e;
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({name, " valid"}, 16'(fifo_dout_valid), 16'h0001);
      check(name, fifo_dout, e);
    end else begin
      check({name, " valid"}, 16'(fifo_dout_valid), 16'h0000);
      m_unf = 1'b1;
    end
  endtask

  initial begin
    logic [15:0] e;

    vecs[0]  = '{OP_WR,    8'h60, 16'h1111, 16'h0000};
    vecs[1]  = '{OP_WR,    8'h60, 16'h2222, 16'h0000};
    vecs[2]  = '{OP_WR,    8'h60, 16'h3333, 16'h0000};
    vecs[3]  = '{OP_RD,    8'h61, 16'h0000, 16'h0003};
    vecs[4]  = '{OP_POP,   8'h00, 16'h0000, 16'h1111};
    vecs[5]  = '{OP_POP,   8'h00, 16'h0000, 16'h2222};
    vecs[6]  = '{OP_POP,   8'h00, 16'h0000, 16'h3333};
    vecs[7]  = '{OP_EMPTY, 8'h00, 16'h0000, 16'h0001};
    vecs[8]  = '{OP_RD,    8'h61, 16'h0000, 16'h0100};
    vecs[9]  = '{OP_POP,   8'h00, 16'h0000, 16'h3333};
    vecs[10] = '{OP_RD,    8'h61, 16'h0000, 16'h0900};
    vecs[11] = '{OP_WR,    8'h62, 16'h0002, 16'h0000};
    vecs[12] = '{OP_RD,    8'h61, 16'h0000, 16'h0100};
    vecs[13] = '{OP_RDX,   8'h62, 16'h0000, 16'h0000};

    #12;
    check("reset db_out_TX", db_out_TX, 16'h0000);
    check("reset avail", 16'(data_from_TX_avail), 16'h0000);
    check("reset fifo_dout", fifo_dout, 16'h0000);
    check("reset dout_valid", 16'(fifo_dout_valid), 16'h0000);
    check("reset fifo_empty", 16'(fifo_empty), 16'h0001);
    reset = 1'b1;
    tick();
    tick();
    read_status("reset status", 16'h0100);

    for (int i = 0; i < $size(vecs); i++) begin
      case (vecs[i].op)
        OP_WR: begin
          if (vecs[i].addr == 8'h60) push_sb(vecs[i].data);
          else begin
            bus_write(vecs[i].addr, vecs[i].data);
            if (vecs[i].data[1]) begin
              m_ovf = 1'b0;
              m_unf = 1'b0;
            end
          end
        end
        OP_RD: read_status($sformatf("vec%0d status", i), vecs[i].exp);
        OP_POP: begin
          pop_sb($sformatf("vec%0d pop", i));
          check($sformatf("vec%0d dout", i), fifo_dout, vecs[i].exp);
        end
        OP_EMPTY: check($sformatf("vec%0d empty", i), 16'(fifo_empty), vecs[i].exp);
        OP_RDX: begin
          ab = vecs[i].addr;
          read_qualified = 1'b1;
          for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("vec%0d foreign avail", i), 16'(data_from_TX_avail), vecs[i].exp);
          end
          read_qualified = 1'b0;
          tick();
        end
        default: ;
      endcase
    end

    for (int i = 0; i < 40; i++) begin
      push_sb(16'(i));
      read_status($sformatf("wrap%0d count", i), exp_status(sb.size(), m_ovf, m_unf));
      pop_sb($sformatf("wrap%0d pop", i));
    end

    for (int i = 0; i < 17; i++) push_sb(16'(i));
    read_status("overflow status", 16'h0610);
    for (int i = 0; i < 16; i++) pop_sb($sformatf("overflow pop%0d", i));
    check("overflow drained empty", 16'(fifo_empty), 16'h0001);
    read_status("overflow drained status", exp_status(0, m_ovf, m_unf));
    clear_flags();

    for (int i = 0; i < 16; i++) push_sb(16'h0A00 + 16'(i));
    ab = 8'h60;
    db_in = 16'hBEEF;
    write_qualified = 1'b1;
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    e = sb.pop_front();
    m_ovf = 1'b1;
    check("full push+pop valid", 16'(fifo_dout_valid), 16'h0001);
    check("full push+pop dout", fifo_dout, e);
    repeat (3) tick();
    write_qualified = 1'b0;
    tick();
    read_status("full push+pop status", 16'h040F);
    for (int i = 0; i < 15; i++) pop_sb($sformatf("full drain%0d", i));
    check("full drain empty", 16'(fifo_empty), 16'h0001);
    clear_flags();

    push_sb(16'hAAAA);
    push_sb(16'hBBBB);
    ab = 8'h62;
    db_in = 16'h0001;
    write_qualified = 1'b1;
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    check("flush+pop valid", 16'(fifo_dout_valid), 16'h0000);
    repeat (3) tick();
    write_qualified = 1'b0;
    tick();
    sb.delete();
    read_status("flush+pop status", 16'h0100);
    check("flush+pop empty", 16'(fifo_empty), 16'h0001);

    ab = 8'h61;
    read_qualified = 1'b1;
    check("read before edge avail", 16'(data_from_TX_avail), 16'h0000);
    tick();
    check("read after edge avail", 16'(data_from_TX_avail), 16'h0001);
    read_qualified = 1'b0;
    tick();
    check("read end avail", 16'(data_from_TX_avail), 16'h0000);
    check("read end db_out", db_out_TX, 16'h0000);

    push_sb(16'h1234);
    ab = 8'h61;
    read_qualified = 1'b1;
    tick();
    check("mid-read db_out", db_out_TX, 16'h0001);
    reset = 1'b0;
    #1;
    check("async reset db_out", db_out_TX, 16'h0000);
    check("async reset avail", 16'(data_from_TX_avail), 16'h0000);
    check("async reset empty", 16'(fifo_empty), 16'h0001);
    sb.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    read_qualified = 1'b0;
    ab = 8'h60;
    db_in = 16'h5555;
    write_qualified = 1'b1;
    #2;
    reset = 1'b1;
    tick();
    tick();
    write_qualified = 1'b0;
    tick();
    read_status("held strobe after reset status", 16'h0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
